// File: rtl/uart_tx_sched_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Index of the stop bit; bits are 0 start, 1..8 data, 9 stop.
  localparam int unsigned BIT_LAST     = 9;
  // 50 MHz / 9600 baud.
  localparam int unsigned BAUD_DIV_DEF = 5208;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud and bit counters for one UART frame. While run is high the baud
// counter sweeps 0..BAUD_DIV-1; tx_bit_flag marks each counter==0 cycle.
// run is high in the grant cycle (to preload the first flag) and in every
// RUN cycle except the last one, which the caller learns from frame_done.
module uart_baud_gen
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       run,
  output logic       tx_bit_flag,
  output logic [3:0] tx_bit_cnt,
  output logic       frame_done
);

  localparam int unsigned   CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic          active_q, active_d;
  logic          flag_q, flag_d;
  logic          wrap;

  // active_q: the current cycle is a RUN cycle of the frame
  assign wrap       = active_q && (baud_q == BAUD_LAST);
  assign frame_done = wrap && (bit_q == 4'(BIT_LAST));

  // Next counter values; flag is registered so it lines up with counter==0
  always_comb begin
    baud_d   = '0;
    bit_d    = '0;
    active_d = run;
    flag_d   = 1'b0;
    if (run && active_q) begin
      baud_d = wrap ? '0 : baud_q + 1'b1;
      bit_d  = wrap ? bit_q + 4'd1 : bit_q;
    end
    flag_d = run && (baud_d == '0);
  end

  // Counter registers with synchronous reset
  always_ff @(posedge sclk) begin
    if (rst) begin
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      flag_q   <= flag_d;
    end
  end

  assign tx_bit_flag = flag_q;
  assign tx_bit_cnt  = bit_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding one UART transmitter.
// IDLE samples requests, GRANT acks the winner and launches the frame,
// RUN lasts exactly 10*BAUD_DIV cycles driven by uart_baud_gen.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       po_flag,
  output logic [7:0] po_data,
  output logic       tx_bit_flag,
  output logic [3:0] tx_bit_cnt,
  output logic       busy
);

  state_e     state_q, state_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d;
  logic       po_flag_q, po_flag_d;
  logic       busy_q, busy_d;
  logic       last_q, last_d;   // requester granted most recently
  logic [7:0] po_data_q, po_data_d;
  logic       run, frame_done, sel1;

  // Requester 1 wins when alone, or when both ask and 0 won last time
  assign sel1 = req1 && (!req0 || !last_q);
  assign run  = (state_q == GRANT) || ((state_q == RUN) && !frame_done);

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .sclk        (sclk),
    .rst         (rst),
    .run         (run),
    .tx_bit_flag (tx_bit_flag),
    .tx_bit_cnt  (tx_bit_cnt),
    .frame_done  (frame_done)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    po_flag_d = 1'b0;
    busy_d    = busy_q;
    last_d    = last_q;
    po_data_d = po_data_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d   = GRANT;
          ack0_d    = !sel1;
          ack1_d    = sel1;
          po_flag_d = 1'b1;
          busy_d    = 1'b1;
          last_d    = sel1;
          po_data_d = sel1 ? data1 : data0;
        end
      end
      GRANT: state_d = RUN;
      RUN: begin
        if (frame_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; pointer resets to 1 so req0 wins first
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q   <= IDLE;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      po_flag_q <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b1;
      po_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      po_flag_q <= po_flag_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      po_data_q <= po_data_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign po_flag = po_flag_q;
  assign busy    = busy_q;
  assign po_data = po_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with BAUD_DIV=4: cycle model by frame position,
// directed scenarios with literal expectations, then random traffic with a
// serial scoreboard.
module tb_uart_tx_sched;

  localparam int D  = 4;
  localparam int FL = 10 * D;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, po_flag, tx_bit_flag, busy;
  logic [7:0] po_data;
  logic [3:0] tx_bit_cnt;

  int errors = 0;
  int checks = 0;

  always #5 sclk = ~sclk;

  uart_tx_sched #(.BAUD_DIV(D)) dut (
    .sclk(sclk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .po_flag(po_flag), .po_data(po_data),
    .tx_bit_flag(tx_bit_flag), .tx_bit_cnt(tx_bit_cnt), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
  endtask

  // Model: a frame is a position k counted from the grant cycle (k=0);
  // k=1..FL are the bit cycles, then one idle cycle before the next sample.
  bit         m_in = 0;
  int         m_k = 0;
  int         m_sel = 0;
  bit         m_last = 1;
  logic [7:0] m_data = '0;
  bit         started = 0;

  always @(posedge sclk) begin
    if (rst) begin
      m_in = 0; m_k = 0; m_last = 1; m_data = '0; started = 1;
    end else if (m_in) begin
      m_k++;
      if (m_k > FL) m_in = 0;
    end else if (req0 || req1) begin
      m_sel  = (req0 && req1) ? (m_last ? 0 : 1) : (req0 ? 0 : 1);
      m_last = (m_sel == 1);
      m_data = (m_sel == 1) ? data1 : data0;
      m_in   = 1;
      m_k    = 0;
    end
  end

  // Compare every cycle, and decode the attached transmitter's line
  bit         e_pf, e_fl;
  int         e_cnt, idx, frames = 0;
  logic [7:0] sb_exp = '0, rx = '0;
  logic       line;

  always @(negedge sclk) begin
    if (started) begin
      e_pf  = m_in && (m_k == 0);
      e_fl  = m_in && (m_k >= 1) && (((m_k - 1) % D) == 0);
      e_cnt = (m_in && m_k >= 1) ? (m_k - 1) / D : 0;
      chk("ack0", ack0, e_pf && m_sel == 0);
      chk("ack1", ack1, e_pf && m_sel == 1);
      chk("po_flag", po_flag, e_pf);
      chk("po_data", po_data, m_data);
      chk("busy", busy, m_in);
      chk("tx_bit_flag", tx_bit_flag, e_fl);
      chk("tx_bit_cnt", tx_bit_cnt, e_cnt);
      if (e_pf) begin sb_exp = m_data; rx = '0; end
      if (tx_bit_flag) begin
        idx  = int'(tx_bit_cnt);
        line = (idx >= 1 && idx <= 8) ? po_data[idx-1] : (idx == 9);
        if (idx >= 1 && idx <= 8) rx[idx-1] = line;
        if (idx == 9) begin
          chk("serial_byte", rx, sb_exp);
          frames++;
        end
      end
    end
  end

  // Random requesters: re-raise after ack, occasionally withdraw
  bit rand_mode = 0;
  always @(negedge sclk) begin
    if (rand_mode) begin
      if (ack0) begin
        req0 = ($urandom_range(3) != 0); data0 = 8'($urandom);
      end else if (!req0 && $urandom_range(7) == 0) begin
        req0 = 1; data0 = 8'($urandom);
      end else if (req0 && $urandom_range(150) == 0) req0 = 0;
      if (ack1) begin
        req1 = ($urandom_range(3) != 0); data1 = 8'($urandom);
      end else if (!req1 && $urandom_range(7) == 0) begin
        req1 = 1; data1 = 8'($urandom);
      end else if (req1 && $urandom_range(150) == 0) req1 = 0;
    end
  end

  int         bc, nf, lastf, ng, np, na, f0;
  bit         found;
  int         gs[3];
  logic [7:0] gd[3];
  int         pt[4];

  initial begin
    // Reset state
    rst = 1; repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_po_data", po_data, 0);
    chk("rst_cnt", tx_bit_cnt, 0);
    chk("rst_po_flag", po_flag, 0);
    rst = 0; tick(); tick();

    // Single byte
    req0 = 1; data0 = 8'hA5; tick();
    chk("a_ack0", ack0, 1);
    chk("a_po_flag", po_flag, 1);
    chk("a_po_data", po_data, 8'hA5);
    req0 = 0;
    bc = 0; nf = 0; lastf = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy) bc++;
      if (tx_bit_flag) begin
        chk("a_cnt", tx_bit_cnt, nf);
        if (nf == 0) chk("a_first_flag", c, 1);
        else chk("a_gap", c - lastf, 4);
        lastf = c; nf++;
      end
      tick();
    end
    chk("a_busy_len", bc, 41);
    chk("a_nflags", nf, 10);

    // Simultaneous requests from reset
    rst = 1; req0 = 1; data0 = 8'h11; req1 = 1; data1 = 8'h22; tick(); tick();
    rst = 0; ng = 0;
    for (int c = 0; c < 300 && ng < 3; c++) begin
      tick();
      chk("b_ack_excl", ack0 && ack1, 0);
      chk("b_ack_pf", ack0 || ack1, po_flag);
      if (ack0 || ack1) begin gs[ng] = ack1; gd[ng] = po_data; ng++; end
    end
    chk("b_ngrants", ng, 3);
    chk("b_g0", {gs[0], gd[0]}, {32'd0, 8'h11});
    chk("b_g1", {gs[1], gd[1]}, {32'd1, 8'h22});
    chk("b_g2", {gs[2], gd[2]}, {32'd0, 8'h11});

    // Back-to-back on req1 only
    req0 = 0; np = 1; pt[0] = 0;
    for (int c = 1; c < 400 && np < 4; c++) begin
      tick();
      if (po_flag) begin pt[np] = c; np++; end
      if (ack1) data1 = 8'($urandom);
    end
    chk("c_npf", np, 4);
    for (int i = 1; i < 4; i++) chk("c_spacing", pt[i] - pt[i-1], 42);

    // Reset mid-frame with a pending req0
    req1 = 0; req0 = 1; data0 = 8'h3C; found = 0;
    for (int c = 0; c < 200 && !found; c++) begin tick(); found = ack0; end
    chk("d_got_ack0", found, 1);
    data0 = 8'h5A; found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick(); found = tx_bit_flag && (tx_bit_cnt == 4);
    end
    chk("d_reached_bit4", found, 1);
    rst = 1; tick();
    chk("d_rst_outs", {ack0, ack1, po_flag, busy, tx_bit_flag, tx_bit_cnt, po_data}, 0);
    rst = 0; tick();
    chk("d_regrant_ack0", ack0, 1);
    chk("d_regrant_data", po_data, 8'h5A);
    req0 = 0;

    // Withdrawn request during RUN
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick(); found = tx_bit_flag && (tx_bit_cnt == 2);
    end
    chk("e_reached_bit2", found, 1);
    req1 = 1; data1 = 8'h77; tick(); req1 = 0;
    na = 0; np = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (ack1) na++;
      if (po_flag) np++;
    end
    chk("e_no_ack1", na, 0);
    chk("e_no_frame", np, 0);

    // Random traffic, 256 serialised bytes
    f0 = frames; rand_mode = 1;
    for (int c = 0; c < 40000 && frames < f0 + 256; c++) tick();
    chk("f_frames", frames - f0, 256);
    rand_mode = 0; req0 = 0; req1 = 0;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
